// File: rtl/systolic_pkg.sv
// Shared constants and helpers for the systolic array skew/deskew stages.
package systolic_pkg;

   localparam int DEF_MATRIX_SIZE = 2;
   localparam int DEF_DATA_SIZE   = 32;
   localparam int MAX_MATRIX_SIZE = 64;

   // Number of registers lane `lane` needs so all lanes line up. The skewer
   // and deskewer use the same helper so their delays always complement.
   function automatic int lane_delay(input int matrix_size, input int lane);
      return matrix_size - lane;
   endfunction

   // Width of a 0..n-1 index, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/VX_shift_register.sv
// Enabled shift register with optional reset on the low RESETW bits.
// Taps are the last NTAPS stages, the oldest entry on the top tap.
module VX_shift_register #(
   parameter int DATAW  = 1,
   parameter int RESETW = 0,
   parameter int DEPTH  = 1,
   parameter int NTAPS  = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [DATAW-1:0]            data_in,
   output logic [NTAPS-1:0][DATAW-1:0] data_out
);

   logic [DEPTH-1:0][DATAW-1:0] entries;

   if (RESETW == 0) begin : g_noreset
      logic [DEPTH-1:0][DATAW-1:0] pipe;
      // Unreset storage; it holds while reset is high so nothing is captured then.
      always_ff @(posedge clk) begin
         if (enable && !reset) begin
            for (int k = DEPTH-1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= data_in;
         end
      end
      assign entries = pipe;
   end else if (RESETW == DATAW) begin : g_reset
      logic [DEPTH-1:0][DATAW-1:0] pipe;
      // Fully reset storage.
      always_ff @(posedge clk) begin
         if (reset) begin
            pipe <= '0;
         end else if (enable) begin
            for (int k = DEPTH-1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= data_in;
         end
      end
      assign entries = pipe;
   end else begin : g_mixed
      logic [DEPTH-1:0][RESETW-1:0]       pipe_r;
      logic [DEPTH-1:0][DATAW-RESETW-1:0] pipe_n;
      // Low bits are reset, high bits only hold during reset.
      always_ff @(posedge clk) begin
         if (reset) begin
            pipe_r <= '0;
         end else if (enable) begin
            for (int k = DEPTH-1; k > 0; k--) begin
               pipe_r[k] <= pipe_r[k-1];
               pipe_n[k] <= pipe_n[k-1];
            end
            pipe_r[0] <= data_in[RESETW-1:0];
            pipe_n[0] <= data_in[DATAW-1:RESETW];
         end
      end
      for (genvar k = 0; k < DEPTH; k++) begin : g_join
         assign entries[k] = {pipe_n[k], pipe_r[k]};
      end
   end

   for (genvar t = 0; t < NTAPS; t++) begin : g_tap
      assign data_out[t] = entries[DEPTH-NTAPS+t];
   end

endmodule

// File: rtl/output_deskewer.sv
// Realigns the skewed columns of a systolic array into whole result rows.
// Lane i arrives i cycles after lane 0, so it is delayed MATRIX_SIZE-i cycles.
// MATRIX_SIZE legal range is 1..64.
module output_deskewer
   import systolic_pkg::*;
#(
   parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
   parameter int DATA_SIZE   = DEF_DATA_SIZE
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  enable_in,
   input  logic                                  valid_in,
   input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data,
   output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_aligned,
   output logic                                  valid_out,
   output logic [idx_width(MATRIX_SIZE)-1:0]     row_idx,
   output logic                                  last_out
);

   localparam int CNTW = idx_width(MATRIX_SIZE);

   logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] lane_out;
   logic [MATRIX_SIZE:1]                  vld_pipe;
   logic [MATRIX_SIZE:0]                  vld_cat;
   logic [CNTW-1:0]                       cnt;
   logic                                  cnt_last;

   for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
      VX_shift_register #(
         .DATAW  (DATA_SIZE),
         .RESETW (0),
         .DEPTH  (lane_delay(MATRIX_SIZE, i)),
         .NTAPS  (1)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .enable   (enable_in),
         .data_in  (data[i]),
         .data_out (lane_out[i])
      );
   end

   assign vld_cat = {vld_pipe, valid_in};

   // Valid travels beside lane 0, MATRIX_SIZE enabled stages deep.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
      end else if (enable_in) begin
         vld_pipe <= vld_cat[MATRIX_SIZE-1:0];
      end
   end

   assign valid_out = vld_pipe[MATRIX_SIZE];
   assign cnt_last  = (cnt == CNTW'(MATRIX_SIZE-1));

   // Row counter advances once per emitted row and wraps at MATRIX_SIZE-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (enable_in && valid_out) begin
         cnt <= cnt_last ? '0 : cnt + CNTW'(1);
      end
   end

   assign row_idx  = cnt;
   assign last_out = valid_out && cnt_last;

   // Lane storage is unreset, so the row is gated by valid; this also makes
   // data_aligned read zero right after reset.
   always_comb begin
      data_aligned = '0;
      if (valid_out) data_aligned = lane_out;
   end

endmodule

// File: tb/tb_output_deskewer.sv
// Directed plus random bench for output_deskewer (MATRIX_SIZE 4 and 1).
// The reference model records every sampled row by enabled-cycle number and
// predicts each output from that history.
module tb_output_deskewer;

   localparam int M    = 4;
   localparam int W    = 32;
   localparam int NMAX = 1024;

   logic                clk = 1'b0;
   logic                reset, enable_in, valid_in;
   logic [M-1:0][W-1:0] data, data_aligned;
   logic                valid_out, last_out;
   logic [1:0]          row_idx;
   logic [0:0][W-1:0]   data1, data_aligned1;
   logic                valid_out1, last_out1;
   logic [0:0]          row_idx1;

   int errors = 0;
   int checks = 0;

   // Model state: ec = enabled, non-reset samples so far; mark = ec at last reset.
   int           ec   = 0;
   int           mark = 0;
   bit           vin_hist [NMAX];
   logic [W-1:0] rowdat   [NMAX][M];
   logic [W-1:0] d1_hist  [NMAX];
   logic [W-1:0] nxt_row  [M];
   logic [W-1:0] nxt1;

   output_deskewer #(.MATRIX_SIZE(M), .DATA_SIZE(W)) dut4 (
      .clk(clk), .reset(reset), .enable_in(enable_in), .valid_in(valid_in),
      .data(data), .data_aligned(data_aligned), .valid_out(valid_out),
      .row_idx(row_idx), .last_out(last_out)
   );

   output_deskewer #(.MATRIX_SIZE(1), .DATA_SIZE(W)) dut1 (
      .clk(clk), .reset(reset), .enable_in(enable_in), .valid_in(valid_in),
      .data(data1), .data_aligned(data_aligned1), .valid_out(valid_out1),
      .row_idx(row_idx1), .last_out(last_out1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_next();
      for (int i = 0; i < M; i++) nxt_row[i] = $urandom;
      nxt1 = $urandom;
   endtask

   task automatic check_outputs(input bit rst);
      int                  j4, j1, cnt;
      bit                  ev4, ev1;
      logic [M-1:0][W-1:0] exp_row;
      j4  = ec - M;
      j1  = ec - 1;
      ev4 = (j4 >= mark) ? vin_hist[j4] : 1'b0;
      ev1 = (j1 >= mark) ? vin_hist[j1] : 1'b0;
      // Rows already emitted since reset decide this row's index.
      cnt = 0;
      for (int j = mark; j < j4; j++) if (vin_hist[j]) cnt++;
      chk("valid_out", valid_out, ev4);
      if (ev4) begin
         for (int i = 0; i < M; i++) exp_row[i] = rowdat[j4][i];
         chk("data_aligned", data_aligned, exp_row);
         chk("row_idx", row_idx, cnt % M);
         chk("last_out", last_out, (cnt % M) == M-1);
      end else begin
         chk("last_out_idle", last_out, 1'b0);
      end
      if (rst) begin
         chk("reset_data", data_aligned, '0);
         chk("reset_row_idx", row_idx, '0);
      end
      chk("m1_valid_out", valid_out1, ev1);
      chk("m1_last_out", last_out1, ev1);
      chk("m1_row_idx", row_idx1, 1'b0);
      if (ev1) chk("m1_data", data_aligned1, d1_hist[j1]);
   endtask

   // One clock: drive inputs, take the edge, advance the model, check.
   task automatic step(input bit en, input bit vin, input bit rst);
      int j;
      reset     = rst;
      enable_in = en;
      valid_in  = vin;
      data[0]   = nxt_row[0];
      for (int i = 1; i < M; i++) begin
         j = ec - i;
         data[i] = (j >= mark && vin_hist[j]) ? rowdat[j][i] : $urandom;
      end
      data1[0] = nxt1;
      @(posedge clk);
      #1;
      if (rst) begin
         mark = ec;
      end else if (en) begin
         vin_hist[ec] = vin;
         rowdat[ec]   = nxt_row;
         d1_hist[ec]  = nxt1;
         ec++;
      end
      check_outputs(rst);
      randomize_next();
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; enable_in = 1'b0; valid_in = 1'b0;
      data = '0; data1 = '0;
      randomize_next();

      // Reset with enable low still clears everything.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);

      // Single row with lane i = 0x10+i.
      for (int i = 0; i < M; i++) nxt_row[i] = 32'h10 + i;
      step(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      chk("single_valid", valid_out, 1'b1);
      chk("single_data", data_aligned, {32'h13, 32'h12, 32'h11, 32'h10});
      chk("single_idx", row_idx, 2'd0);
      repeat (3) step(1'b1, 1'b0, 1'b0);

      // Four back-to-back rows, lane i of row r = 0x100*r+i.
      do_reset();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < M; i++) nxt_row[i] = 32'h100 * r + i;
         step(1'b1, 1'b1, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("b2b_last_idx", row_idx, 2'd3);
      chk("b2b_last_out", last_out, 1'b1);
      chk("b2b_last_data", data_aligned, {32'h303, 32'h302, 32'h301, 32'h300});
      repeat (3) step(1'b1, 1'b0, 1'b0);

      // Stall of three cycles two cycles after valid_in; then stall on a valid row.
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("stall_not_yet", valid_out, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("stall_valid", valid_out, 1'b1);
      repeat (2) step(1'b0, 1'b1, 1'b0);
      chk("stall_frozen", valid_out, 1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b0);

      // Reset two cycles after valid_in discards the row.
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      repeat (9) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      chk("post_reset_valid", valid_out, 1'b1);
      chk("post_reset_idx", row_idx, 2'd0);

      // Five back-to-back rows: the fifth wraps to index 0.
      do_reset();
      repeat (5) step(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      chk("wrap_idx", row_idx, 2'd0);
      chk("wrap_last", last_out, 1'b0);
      chk("wrap_valid", valid_out, 1'b1);
      repeat (2) step(1'b1, 1'b0, 1'b0);

      // Random traffic with stalls and occasional reset.
      repeat (400) begin
         if (ec >= NMAX - 8) break;
         step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 59) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
